// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory read-port arbiter: word/address/size types,
// the `WORD access size and the in-flight owner encoding.
`ifndef WORD
`define WORD 2'd2
`endif

package mem_port_arbiter_pkg;

    typedef logic [31:0] word;
    typedef logic [31:0] word_address;
    typedef logic [1:0]  load_type;

    localparam load_type SIZE_BYTE = 2'd0;
    localparam load_type SIZE_HALF = 2'd1;
    localparam load_type SIZE_WORD = `WORD;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory read port between fetch and load, routing data
// back to the owner one cycle later. Define STARVATION_GUARD_EN for fetch anti-starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOAD_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_request,
    input  word_address fetch_address,
    input  logic        fetch_flush,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output word         fetch_data,
    input  logic        load_request,
    input  word_address load_address,
    input  load_type    load_size,
    output logic        load_ready,
    output logic        load_valid,
    output word         load_data,
    output word_address long_addr,
    output load_type    how_much,
    input  word         content
);

    logic        grant_load;
    logic        grant_fetch;
    logic        fetch_wins;
    owner_t      owner;
    owner_t      owner_next;
    word_address addr_q;
    load_type    size_q;

`ifdef STARVATION_GUARD_EN
    logic [3:0] streak;

    assign fetch_wins = (streak == 4'(MAX_LOAD_STREAK))
                        && fetch_request && !fetch_flush;

    // Saturates so a flushed fetch still wins once the flush drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak <= 4'd0;
        end else if (grant_fetch || !fetch_request) begin
            streak <= 4'd0;
        end else if (grant_load && streak < 4'(MAX_LOAD_STREAK)) begin
            streak <= streak + 4'd1;
        end
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(MAX_LOAD_STREAK);
    assign fetch_wins = 1'b0;
`endif

    always_comb begin
        grant_load  = 1'b0;
        grant_fetch = 1'b0;
        if (!reset) begin
            if (load_request && !fetch_wins) begin
                grant_load = 1'b1;
            end else if (fetch_request && !fetch_flush) begin
                grant_fetch = 1'b1;
            end
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (grant_load) begin
            owner_next = OWN_LOAD;
        end else if (grant_fetch) begin
            owner_next = OWN_FETCH;
        end
    end

    always_comb begin
        long_addr = addr_q;
        how_much  = size_q;
        if (reset) begin
            long_addr = '0;
            how_much  = `WORD;
        end else if (grant_load) begin
            long_addr = load_address;
            how_much  = load_size;
        end else if (grant_fetch) begin
            long_addr = fetch_address;
            how_much  = `WORD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner  <= OWN_NONE;
            addr_q <= '0;
            size_q <= `WORD;
        end else begin
            owner <= owner_next;
            if (grant_load || grant_fetch) begin
                addr_q <= long_addr;
                size_q <= how_much;
            end
        end
    end

    assign fetch_ready = grant_fetch;
    assign load_ready  = grant_load;

    // Reset and flush both squash data already in flight.
    assign fetch_valid = !reset && !fetch_flush && (owner == OWN_FETCH);
    assign load_valid  = !reset && (owner == OWN_LOAD);
    assign fetch_data  = fetch_valid ? content : '0;
    assign load_data   = load_valid ? content : '0;

endmodule
